// File: rtl/mux_alu_pkg.sv
// ============================================================================
// mux_alu_pkg : function codes and FSM state encoding for mux_alu_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux_alu_pkg;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_logic_unit.sv
// ============================================================================
// mux_logic_unit : bitwise AND/OR/XOR/NAND built only from 2:1 muxes
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mux_logic_unit
    import mux_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   fn,
    output logic [W-1:0] y
);

    // Per bit: fn picks the (in0, in1) data pair, then bit a selects between them.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic w_nb;
        logic w_in0_lo;
        logic w_in0_hi;
        logic w_in0;
        logic w_in1_lo;
        logic w_in1;

        assign w_nb     = ~b[i];
        assign w_in0_lo = fn[0] ? b[i]  : 1'b0;
        assign w_in0_hi = fn[0] ? 1'b1  : b[i];
        assign w_in0    = fn[1] ? w_in0_hi : w_in0_lo;
        assign w_in1_lo = fn[0] ? 1'b1  : b[i];
        assign w_in1    = fn[1] ? w_nb  : w_in1_lo;
        assign y[i]     = a[i]  ? w_in1 : w_in0;
    end

endmodule

`default_nettype wire

// File: rtl/mux_alu_arbiter.sv
// ============================================================================
// mux_alu_arbiter : round-robin sharing of one mux logic unit among NREQ users
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mux_alu_arbiter
    import mux_alu_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    input  logic [NREQ*2-1:0] fn,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [W-1:0]      res
);

    state_t         r_state;
    state_t         w_state_nx;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_cur_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [1:0]     r_fn;
    logic [IDW-1:0] w_sel_id;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic [W-1:0]   w_y;

    // NREQ is a power of two, so IDW-bit addition wraps the scan for free.
    always_comb begin
        w_sel_id = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_ptr + IDW'(k);
            if (!w_found && req[w_idx]) begin
                w_sel_id = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    mux_logic_unit #(.W(W)) u_lu (
        .a  (r_a),
        .b  (r_b),
        .fn (r_fn),
        .y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        gnt        = '0;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nx = GRANT;
                end
            end
            GRANT: begin
                gnt[r_cur_id] = 1'b1;
                busy          = 1'b1;
                w_state_nx    = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_cur_id  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_fn      <= '0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (r_state == IDLE && |req) begin
                r_cur_id <= w_sel_id;
                r_a      <= op_a[w_sel_id*W +: W];
                r_b      <= op_b[w_sel_id*W +: W];
                r_fn     <= fn[w_sel_id*2 +: 2];
            end
            // ptr only advances on completion, so an aborted op leaves fairness untouched.
            if (r_state == EXEC) begin
                res       <= w_y;
                res_id    <= r_cur_id;
                res_valid <= 1'b1;
                r_ptr     <= r_cur_id + IDW'(1);
            end
        end
    end

endmodule

`default_nettype wire
